code_mem_arbiter: RTL and testbench



---
 rtl/code_mem_arbiter.sv | 94 +++++++++
 tb/tb_code_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/code_mem_arbiter.sv
// Arbitrates the single-port code memory between instruction fetch (F) and data reads (D).
// Define CODE_MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over F.
module code_mem_arbiter #(
    parameter int ADDRWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_req,
    input  logic [ADDRWIDTH-1:0] f_addr,
    output logic                 f_ack,
    input  logic                 d_req,
    input  logic [ADDRWIDTH-1:0] d_addr,
    output logic                 d_ack,
    output logic [7:0]           rdata,
    output logic                 mem_cs_n,
    output logic [ADDRWIDTH-1:0] mem_addr,
    input  logic [7:0]           mem_dout,
    output logic                 busy,
    output logic                 gnt_d
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   win_d;

`ifdef CODE_MEM_ARB_RR_EN
    // Pointer names the port that wins a tie: 0 = F next, 1 = D next.
    logic rr_d;

    always_comb begin
        win_d = d_req && (!f_req || rr_d);
    end
`else
    always_comb begin
        win_d = d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_cs_n <= 1'b1;
            mem_addr <= '0;
            rdata    <= 8'h00;
            f_ack    <= 1'b0;
            d_ack    <= 1'b0;
            busy     <= 1'b0;
            gnt_d    <= 1'b0;
`ifdef CODE_MEM_ARB_RR_EN
            rr_d     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    f_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (f_req || d_req) begin
                        gnt_d    <= win_d;
                        mem_addr <= win_d ? d_addr : f_addr;
                        mem_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        state    <= READ;
`ifdef CODE_MEM_ARB_RR_EN
                        rr_d     <= !win_d;
`endif
                    end
                end
                READ: begin
                    // Memory latched the address on the negedge; its byte is stable now.
                    rdata    <= mem_dout;
                    mem_cs_n <= 1'b1;
                    f_ack    <= !gnt_d;
                    d_ack    <= gnt_d;
                    state    <= RESP;
                end
                RESP: begin
                    f_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_mem_arbiter.sv
// Directed bench for code_mem_arbiter with a behavioural code memory.
module tb_code_mem_arbiter;

    localparam int AW = 8;
`ifdef CODE_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req, d_req;
    logic [AW-1:0] f_addr, d_addr;
    logic          f_ack, d_ack;
    logic [7:0]    rdata;
    logic          mem_cs_n;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dout;
    logic          busy, gnt_d;

    logic [7:0]    mem [0:255];
    int            vecs = 0;
    int            errs = 0;

    code_mem_arbiter #(.ADDRWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack),
        .rdata(rdata), .mem_cs_n(mem_cs_n), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .busy(busy), .gnt_d(gnt_d)
    );

    always #5 clk = ~clk;

    // Memory returns garbage when deselected so a mistimed capture shows up.
    always @(negedge clk) begin
        if (!mem_cs_n) mem_dout <= mem[mem_addr];
        else           mem_dout <= 8'hA5;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        vecs++; if (mem_cs_n !== 1'b1) begin errs++; $display("FAIL reset_cs_n got %b want 1", mem_cs_n); end
        vecs++; if (mem_addr !== 8'h00) begin errs++; $display("FAIL reset_addr got %h want 00", mem_addr); end
        vecs++; if (rdata !== 8'h00) begin errs++; $display("FAIL reset_rdata got %h want 00", rdata); end
        vecs++; if ({f_ack, d_ack, busy, gnt_d} !== 4'b0000) begin errs++; $display("FAIL reset_ctl got %b want 0000", {f_ack, d_ack, busy, gnt_d}); end
    endtask

    task automatic test_single_fetch;
        do_reset();
        f_req = 1'b1; f_addr = 8'h02;
        tick();
        vecs++; if (mem_cs_n !== 1'b0) begin errs++; $display("FAIL fetch_cs_n got %b want 0", mem_cs_n); end
        vecs++; if (mem_addr !== 8'h02) begin errs++; $display("FAIL fetch_addr got %h want 02", mem_addr); end
        vecs++; if ({busy, gnt_d, f_ack} !== 3'b100) begin errs++; $display("FAIL fetch_grant got %b want 100", {busy, gnt_d, f_ack}); end
        tick();
        vecs++; if (f_ack !== 1'b1) begin errs++; $display("FAIL fetch_ack got %b want 1", f_ack); end
        vecs++; if (rdata !== 8'hE8) begin errs++; $display("FAIL fetch_rdata got %h want e8", rdata); end
        vecs++; if ({d_ack, mem_cs_n, gnt_d} !== 3'b010) begin errs++; $display("FAIL fetch_resp got %b want 010", {d_ack, mem_cs_n, gnt_d}); end
        tick();
        f_req = 1'b0;
        vecs++; if ({f_ack, d_ack, busy} !== 3'b000) begin errs++; $display("FAIL fetch_idle got %b want 000", {f_ack, d_ack, busy}); end
        tick();
        vecs++; if (mem_cs_n !== 1'b1) begin errs++; $display("FAIL fetch_no_reread got %b want 1", mem_cs_n); end
    endtask

    task automatic test_simultaneous;
        logic first_d;
        do_reset();
        first_d = !RR;
        d_req = 1'b1; d_addr = 8'h01; f_req = 1'b1; f_addr = 8'h03;
        tick();
        vecs++; if (gnt_d !== first_d) begin errs++; $display("FAIL simul_gnt1 got %b want %b", gnt_d, first_d); end
        tick();
        vecs++; if ({d_ack, f_ack} !== {first_d, !first_d}) begin errs++; $display("FAIL simul_ack1 got %b want %b", {d_ack, f_ack}, {first_d, !first_d}); end
        vecs++; if (rdata !== (first_d ? 8'h55 : 8'hFF)) begin errs++; $display("FAIL simul_rdata1 got %h want %h", rdata, first_d ? 8'h55 : 8'hFF); end
        tick();
        if (first_d) d_req = 1'b0; else f_req = 1'b0;
        tick();
        vecs++; if (gnt_d !== !first_d) begin errs++; $display("FAIL simul_gnt2 got %b want %b", gnt_d, !first_d); end
        tick();
        vecs++; if ({d_ack, f_ack} !== {!first_d, first_d}) begin errs++; $display("FAIL simul_ack2 got %b want %b", {d_ack, f_ack}, {!first_d, first_d}); end
        vecs++; if (rdata !== (first_d ? 8'hFF : 8'h55)) begin errs++; $display("FAIL simul_rdata2 got %h want %h", rdata, first_d ? 8'hFF : 8'h55); end
        tick();
        d_req = 1'b0; f_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic exp_d;
        do_reset();
        d_req = 1'b1; d_addr = 8'h01; f_req = 1'b1; f_addr = 8'h03;
        for (int g = 0; g < 4; g++) begin
            exp_d = RR ? g[0] : 1'b1;
            tick();
            vecs++; if (gnt_d !== exp_d) begin errs++; $display("FAIL b2b_gnt%0d got %b want %b", g, gnt_d, exp_d); end
            tick();
            vecs++; if ({d_ack, f_ack} !== {exp_d, !exp_d}) begin errs++; $display("FAIL b2b_ack%0d got %b want %b", g, {d_ack, f_ack}, {exp_d, !exp_d}); end
            vecs++; if (rdata !== (exp_d ? 8'h55 : 8'hFF)) begin errs++; $display("FAIL b2b_rdata%0d got %h want %h", g, rdata, exp_d ? 8'h55 : 8'hFF); end
            tick();
            vecs++; if ({d_ack, f_ack} !== 2'b00) begin errs++; $display("FAIL b2b_ackdrop%0d got %b want 00", g, {d_ack, f_ack}); end
        end
        d_req = 1'b0; f_req = 1'b0;
        tick();
    endtask

    task automatic test_addr_change;
        do_reset();
        f_req = 1'b1; f_addr = 8'h00;
        tick();
        f_addr = 8'h03;
        tick();
        vecs++; if (rdata !== 8'h78) begin errs++; $display("FAIL addrchg_rdata got %h want 78", rdata); end
        vecs++; if (mem_addr !== 8'h00) begin errs++; $display("FAIL addrchg_addr got %h want 00", mem_addr); end
        tick();
        f_req = 1'b0;
        tick();
        vecs++; if (mem_addr !== 8'h00) begin errs++; $display("FAIL addrchg_hold got %h want 00", mem_addr); end
    endtask

    task automatic test_reset_mid_read;
        do_reset();
        d_req = 1'b1; d_addr = 8'h03;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; d_req = 1'b0;
        vecs++; if (d_ack !== 1'b0) begin errs++; $display("FAIL abort_ack got %b want 0", d_ack); end
        vecs++; if ({mem_cs_n, busy} !== 2'b10) begin errs++; $display("FAIL abort_ctl got %b want 10", {mem_cs_n, busy}); end
        vecs++; if (rdata !== 8'h00) begin errs++; $display("FAIL abort_rdata got %h want 00", rdata); end
        tick();
        vecs++; if ({d_ack, f_ack, mem_cs_n} !== 3'b001) begin errs++; $display("FAIL abort_after got %b want 001", {d_ack, f_ack, mem_cs_n}); end
    endtask

    task automatic test_fetch_stream;
        logic [7:0] exp [0:3];
        int         acks;
        exp[0] = 8'h78; exp[1] = 8'h55; exp[2] = 8'hE8; exp[3] = 8'hFF;
        acks = 0;
        do_reset();
        f_req = 1'b1; f_addr = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            acks += int'(f_ack);
            tick();
            acks += int'(f_ack);
            vecs++; if (f_ack !== 1'b1 || rdata !== exp[i]) begin errs++; $display("FAIL stream%0d got ack=%b rdata=%h want ack=1 rdata=%h", i, f_ack, rdata, exp[i]); end
            tick();
            acks += int'(f_ack);
            f_addr = f_addr + 8'h01;
            if (i == 3) f_req = 1'b0;
        end
        vecs++; if (acks !== 4) begin errs++; $display("FAIL stream_ack_count got %0d want 4", acks); end
        tick();
        vecs++; if ({mem_cs_n, busy} !== 2'b10) begin errs++; $display("FAIL stream_end got %b want 10", {mem_cs_n, busy}); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[0] = 8'h78; mem[1] = 8'h55; mem[2] = 8'hE8; mem[3] = 8'hFF;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_back_to_back();
        test_addr_change();
        test_reset_mid_read();
        test_fetch_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
